// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 writer: word field positions, FSM encoding and the
// clear/return-home decoder.
package lcd_pkg;

  localparam int unsigned WORD_W     = 10;
  localparam int unsigned RS_BIT     = 9;
  localparam int unsigned SINGLE_BIT = 8;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StPulse,
    StHold,
    StExec
  } state_e;

  // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] cmd);
    return !rs && (cmd[7:2] == 6'd0) && (cmd[1:0] != 2'd0);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_cycle_timer.sv
// Loadable down-counter. A load of N-1 makes done assert N cycles later, so a state entered
// with that load lasts exactly N cycles.
module lcd_cycle_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] count_q;

  assign done = (count_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (!done) begin
      count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/hd44780_writer.sv
// Pops command/data words from the LCD FIFO and drives an HD44780 bus in 8-bit or 4-bit mode
// with cycle-counted setup, enable, hold and execution timing.
module hd44780_writer
  import lcd_pkg::*;
#(
  parameter int unsigned BUS_WIDTH        = 8,
  parameter int unsigned SETUP_CYCLES     = 2,
  parameter int unsigned PULSE_CYCLES     = 13,
  parameter int unsigned HOLD_CYCLES      = 14,
  parameter int unsigned EXEC_CYCLES      = 1100,
  parameter int unsigned LONG_EXEC_CYCLES = 41100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_W-1:0]    in_data,
  output logic                 lcd_rs,
  output logic                 lcd_rw,
  output logic                 lcd_e,
  output logic [BUS_WIDTH-1:0] lcd_db
);

  localparam int unsigned MaxCycles = max_u(max_u(max_u(SETUP_CYCLES, PULSE_CYCLES),
                                                  max_u(HOLD_CYCLES, EXEC_CYCLES)),
                                            LONG_EXEC_CYCLES);
  localparam int unsigned CntW = $clog2(MaxCycles) + 1;

  localparam logic [CntW-1:0] SetupLd    = CntW'(SETUP_CYCLES - 1);
  localparam logic [CntW-1:0] PulseLd    = CntW'(PULSE_CYCLES - 1);
  localparam logic [CntW-1:0] HoldLd     = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] ExecLd     = CntW'(EXEC_CYCLES - 1);
  localparam logic [CntW-1:0] LongExecLd = CntW'(LONG_EXEC_CYCLES - 1);

  if (BUS_WIDTH != 8 && BUS_WIDTH != 4) begin : g_bad_width
    $error("hd44780_writer: BUS_WIDTH must be 8 or 4");
  end

  state_e          state_q;
  logic [7:0]      byte_q;
  logic            single_q;
  logic            second_q;
  logic            tmr_load;
  logic [CntW-1:0] tmr_val;
  logic            tmr_done;
  logic            need_second;
  logic [7:0]      lo_beat;

  assign in_ready = (state_q == StIdle);
  assign lcd_rw   = 1'b0;

  // A full byte in 4-bit mode still owes its low nibble after the first beat.
  assign need_second = (BUS_WIDTH == 4) && !single_q && !second_q;
  assign lo_beat     = {4'h0, byte_q[3:0]};

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          tmr_load = 1'b1;
          tmr_val  = SetupLd;
        end
      end
      StSetup: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = PulseLd;
        end
      end
      StPulse: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = HoldLd;
        end
      end
      StHold: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          if (need_second) begin
            tmr_val = SetupLd;
          end else if (is_long_cmd(lcd_rs, byte_q)) begin
            tmr_val = LongExecLd;
          end else begin
            tmr_val = ExecLd;
          end
        end
      end
      StExec: begin
        tmr_load = 1'b0;
      end
      default: begin
        tmr_load = 1'b0;
      end
    endcase
  end

  lcd_cycle_timer #(
    .WIDTH(CntW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(tmr_val),
    .done    (tmr_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_db   <= '0;
      byte_q   <= '0;
      single_q <= 1'b0;
      second_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            lcd_rs   <= in_data[RS_BIT];
            lcd_db   <= in_data[7 -: BUS_WIDTH];
            byte_q   <= in_data[7:0];
            single_q <= in_data[SINGLE_BIT];
            second_q <= 1'b0;
            state_q  <= StSetup;
          end
        end
        StSetup: begin
          if (tmr_done) begin
            lcd_e   <= 1'b1;
            state_q <= StPulse;
          end
        end
        StPulse: begin
          if (tmr_done) begin
            lcd_e   <= 1'b0;
            state_q <= StHold;
          end
        end
        StHold: begin
          if (tmr_done) begin
            if (need_second) begin
              lcd_db   <= lo_beat[BUS_WIDTH-1:0];
              second_q <= 1'b1;
              state_q  <= StSetup;
            end else begin
              state_q <= StExec;
            end
          end
        end
        StExec: begin
          if (tmr_done) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hd44780_writer.sv
// Directed bench: one 8-bit and one 4-bit writer with default timing, checked against
// hand-computed pulse positions, bus values and busy lengths.
module tb_hd44780_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       a_valid = 1'b0;
  logic [9:0] a_data  = '0;
  logic       a_ready, a_rs, a_rw, a_e;
  logic [7:0] a_db;

  logic       b_valid = 1'b0;
  logic [9:0] b_data  = '0;
  logic       b_ready, b_rs, b_rw, b_e;
  logic [3:0] b_db;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hd44780_writer #(
    .BUS_WIDTH(8)
  ) u_dut8 (
    .clk     (clk),
    .rst     (rst),
    .in_valid(a_valid),
    .in_ready(a_ready),
    .in_data (a_data),
    .lcd_rs  (a_rs),
    .lcd_rw  (a_rw),
    .lcd_e   (a_e),
    .lcd_db  (a_db)
  );

  hd44780_writer #(
    .BUS_WIDTH(4)
  ) u_dut4 (
    .clk     (clk),
    .rst     (rst),
    .in_valid(b_valid),
    .in_ready(b_ready),
    .in_data (b_data),
    .lcd_rs  (b_rs),
    .lcd_rw  (b_rw),
    .lcd_e   (b_e),
    .lcd_db  (b_db)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sample(input bit four, output logic rdy, output logic e, output logic rs,
                        output logic [7:0] db);
    rdy = four ? b_ready : a_ready;
    e   = four ? b_e : a_e;
    rs  = four ? b_rs : a_rs;
    db  = four ? {4'h0, b_db} : a_db;
  endtask

  // Push one word and follow it until in_ready returns.
  task automatic xfer(input bit four, input logic [9:0] w, input logic exp_rs,
                      input logic [7:0] d0, input logic [7:0] d1, input int npulse,
                      input int busy);
    int   i, pulses, width;
    logic e_prev, rdy, e, rs;
    logic [7:0] db;
    @(negedge clk);
    sample(four, rdy, e, rs, db);
    check_eq("ready_before_push", rdy, 1);
    if (four) begin b_valid = 1'b1; b_data = w; end
    else      begin a_valid = 1'b1; a_data = w; end
    @(posedge clk);
    #1;
    // Garbage while busy must not leak into the bus.
    if (four) begin b_valid = 1'b0; b_data = 10'h3FF; end
    else      begin a_valid = 1'b0; a_data = 10'h3FF; end
    i = 0; pulses = 0; width = 0; e_prev = 1'b0;
    sample(four, rdy, e, rs, db);
    check_eq("rs_after_accept", rs, exp_rs);
    check_eq("db_after_accept", db, d0);
    while (!rdy && i < 50000) begin
      if (e && !e_prev) begin
        pulses++;
        check_eq("e_rise_index", i, 2 + (pulses - 1) * 29);
        check_eq("db_during_e", db, (pulses == 1) ? d0 : d1);
        check_eq("rs_during_e", rs, exp_rs);
      end
      if (e) width++;
      if (!e && e_prev) begin
        check_eq("e_width", width, 13);
        width = 0;
      end
      e_prev = e;
      @(posedge clk);
      #1;
      i++;
      sample(four, rdy, e, rs, db);
    end
    check_eq("busy_cycles", i, busy);
    check_eq("pulse_count", pulses, npulse);
  endtask

  task automatic back_to_back();
    logic [9:0] words [3];
    logic [7:0] exp_db [3];
    int idx, pulses, last;
    logic e_prev;
    words[0] = 10'h028; words[1] = 10'h00C; words[2] = 10'h248;
    exp_db[0] = 8'h28;  exp_db[1] = 8'h0C;  exp_db[2] = 8'h48;
    idx = 0; pulses = 0; last = 0; e_prev = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (a_e && !e_prev) begin
        if (pulses < 3) check_eq("b2b_db", a_db, exp_db[pulses]);
        pulses++;
      end
      e_prev = a_e;
      if (a_ready) begin
        check_eq("b2b_no_e_when_idle", a_e, 0);
        if (idx < 3) begin
          a_valid = 1'b1;
          a_data  = words[idx];
          if (idx > 0) check_eq("b2b_accept_gap", c - last, 1130);
          last = c;
          idx++;
        end else begin
          a_valid = 1'b0;
          break;
        end
      end
    end
    a_valid = 1'b0;
    check_eq("b2b_words_done", idx, 3);
    check_eq("b2b_pulses", pulses, 3);
  endtask

  task automatic reset_mid_pulse();
    @(negedge clk);
    a_valid = 1'b1;
    a_data  = 10'h241;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    for (int k = 0; k < 20 && !a_e; k++) begin
      @(posedge clk);
      #1;
    end
    check_eq("e_before_rst", a_e, 1);
    repeat (3) @(posedge clk);
    #3;
    rst     = 1'b1;
    a_valid = 1'b1;
    #1;
    check_eq("rst_e_async", a_e, 0);
    check_eq("rst_rs", a_rs, 0);
    check_eq("rst_db", a_db, 0);
    check_eq("rst_ready", a_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_no_accept_e", a_e, 0);
    check_eq("rst_no_accept_db", a_db, 0);
    @(negedge clk);
    a_valid = 1'b0;
    rst     = 1'b0;
    @(posedge clk);
    #1;
    check_eq("ready_after_rst", a_ready, 1);
  endtask

  initial begin
    #1;
    check_eq("reset_ready8", a_ready, 1);
    check_eq("reset_e8", a_e, 0);
    check_eq("reset_rs8", a_rs, 0);
    check_eq("reset_db8", a_db, 0);
    check_eq("reset_rw8", a_rw, 0);
    check_eq("reset_e4", b_e, 0);
    check_eq("reset_db4", b_db, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    xfer(1'b0, 10'h241, 1'b1, 8'h41, 8'h00, 1, 1129);
    xfer(1'b0, 10'h001, 1'b0, 8'h01, 8'h00, 1, 41129);
    xfer(1'b0, 10'h080, 1'b0, 8'h80, 8'h00, 1, 1129);
    xfer(1'b1, 10'h2A5, 1'b1, 8'h0A, 8'h05, 2, 1158);
    check_eq("rw4_const", b_rw, 0);
    xfer(1'b1, 10'h130, 1'b0, 8'h03, 8'h00, 1, 1129);
    back_to_back();
    reset_mid_pulse();
    xfer(1'b0, 10'h241, 1'b1, 8'h41, 8'h00, 1, 1129);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
